// File: rtl/ahb_master.sv
// ahb_master: single-outstanding AHB-Lite master bridging a valid/ready request
// port to an AHB bus and returning a one-cycle response strobe.
// Optional feature: define AHB_MASTER_TIMEOUT_EN to abort transfers stalled
// for TIMEOUT_CYCLES consecutive hready_i=0 cycles.
// Ports:
//   hclk_i, hreset_i          clock, synchronous active-high reset
//   req_valid_i/req_ready_o   request handshake
//   req_addr_i, req_wdata_i   request address / write data
//   req_write_i, req_size_i   request direction / AHB size
//   rsp_valid_o               one-cycle response strobe
//   rsp_rdata_o, rsp_err_o    response read data / error flag
//   haddr_o, htrans_o, hwrite_o, hsize_o, hwdata_o   AHB master outputs
//   hrdata_i, hready_i, hresp_i                      AHB slave returns
module ahb_master #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  hclk_i,
    input  logic                  hreset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic                  req_write_i,
    input  logic [2:0]            req_size_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [DATA_WIDTH-1:0] haddr_o,
    output logic [1:0]            htrans_o,
    output logic                  hwrite_o,
    output logic [2:0]            hsize_o,
    output logic [DATA_WIDTH-1:0] hwdata_o,
    input  logic [DATA_WIDTH-1:0] hrdata_i,
    input  logic                  hready_i,
    input  logic [1:0]            hresp_i
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] RESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  misaligned_c;
    logic                  timeout_c;

    // Requests that would be illegal on the bus are answered locally with an error
    always_comb begin
        misaligned_c = 1'b0;
        if (req_size_i > 3'd2)
            misaligned_c = 1'b1;
        else if (req_size_i == 3'd1 && req_addr_i[0])
            misaligned_c = 1'b1;
        else if (req_size_i == 3'd2 && req_addr_i[1:0] != 2'b00)
            misaligned_c = 1'b1;
    end

`ifdef AHB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt;

    // Consecutive stalled bus cycles; any ready cycle or leaving the bus phases clears it
    always_ff @(posedge hclk_i) begin
        if (hreset_i || hready_i || !(state == S_ADDR || state == S_DATA))
            stall_cnt <= '0;
        else
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle
    assign timeout_c = !hready_i && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_c = 1'b0;
`endif

    // Transfer FSM; every output is a register updated here
    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            state       <= S_IDLE;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            haddr_o     <= '0;
            htrans_o    <= TRANS_IDLE;
            hwrite_o    <= 1'b0;
            hsize_o     <= 3'd0;
            hwdata_o    <= '0;
            wdata_q     <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        if (misaligned_c) begin
                            state       <= S_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end else begin
                            state    <= S_ADDR;
                            htrans_o <= TRANS_NONSEQ;
                            haddr_o  <= req_addr_i;
                            hwrite_o <= req_write_i;
                            hsize_o  <= req_size_i;
                            wdata_q  <= req_wdata_i;
                        end
                    end
                end
                S_ADDR: begin
                    if (hready_i) begin
                        state    <= S_DATA;
                        htrans_o <= TRANS_IDLE;
                        hwdata_o <= wdata_q;
                    end else if (timeout_c) begin
                        state       <= S_RESP;
                        htrans_o    <= TRANS_IDLE;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                    end
                end
                S_DATA: begin
                    if (hready_i) begin
                        state       <= S_RESP;
                        rsp_valid_o <= 1'b1;
                        if (hresp_i == RESP_ERROR) begin
                            // Second cycle of the two-cycle ERROR response
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end else begin
                            rsp_err_o <= 1'b0;
                            if (!hwrite_o)
                                rsp_rdata_o <= hrdata_i;
                        end
                    end else if (timeout_c) begin
                        state       <= S_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                    end
                end
                S_RESP: begin
                    state       <= S_IDLE;
                    req_ready_o <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master: directed self-checking bench for ahb_master.
module tb_ahb_master;

    logic        clk = 1'b0;
    logic        hreset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic [2:0]  req_size;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ahb_master #(
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .hclk_i     (clk),
        .hreset_i   (hreset),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .req_write_i(req_write),
        .req_size_i (req_size),
        .rsp_valid_o(rsp_valid),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .haddr_o    (haddr),
        .htrans_o   (htrans),
        .hwrite_o   (hwrite),
        .hsize_o    (hsize),
        .hwdata_o   (hwdata),
        .hrdata_i   (hrdata),
        .hready_i   (hready),
        .hresp_i    (hresp)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return at the following falling edge
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_ready"},  req_ready, 0);
        check_eq({pfx, "_rvalid"}, rsp_valid, 0);
        check_eq({pfx, "_rerr"},   rsp_err,   0);
        check_eq({pfx, "_rdata"},  rsp_rdata, 0);
        check_eq({pfx, "_htrans"}, htrans,    0);
        check_eq({pfx, "_haddr"},  haddr,     0);
        check_eq({pfx, "_hwrite"}, hwrite,    0);
        check_eq({pfx, "_hsize"},  hsize,     0);
        check_eq({pfx, "_hwdata"}, hwdata,    0);
    endtask

    // Zero-wait-state transfer with full cycle-by-cycle checking
    task automatic do_xfer(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic wr, input logic [2:0] size, input logic exp_err,
                           input logic [31:0] rd);
        check_eq({tag, "_ready_pre"}, req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wdata = wdata;
        req_write = wr;
        req_size  = size;
        hrdata    = rd;
        hready    = 1'b1;
        hresp     = 2'b00;
        tick;
        req_valid = 1'b0;
        if (exp_err) begin
            check_eq({tag, "_rej_htrans"}, htrans,    2'b00);
            check_eq({tag, "_rej_rvalid"}, rsp_valid, 1);
            check_eq({tag, "_rej_rerr"},   rsp_err,   1);
        end else begin
            check_eq({tag, "_addr_htrans"}, htrans, 2'b10);
            check_eq({tag, "_addr_haddr"},  haddr,  addr);
            check_eq({tag, "_addr_hwrite"}, hwrite, wr);
            check_eq({tag, "_addr_hsize"},  hsize,  size);
            check_eq({tag, "_addr_ready"},  req_ready, 0);
            tick;
            check_eq({tag, "_data_htrans"}, htrans,    2'b00);
            check_eq({tag, "_data_rvalid"}, rsp_valid, 0);
            if (wr)
                check_eq({tag, "_data_hwdata"}, hwdata, wdata);
            tick;
            check_eq({tag, "_resp_rvalid"}, rsp_valid, 1);
            check_eq({tag, "_resp_rerr"},   rsp_err,   0);
            check_eq({tag, "_resp_ready"},  req_ready, 0);
            if (!wr)
                check_eq({tag, "_resp_rdata"}, rsp_rdata, rd);
        end
        tick;
        check_eq({tag, "_post_rvalid"}, rsp_valid, 0);
        check_eq({tag, "_post_ready"},  req_ready, 1);
    endtask

    initial begin
        bit seen;

        hreset    = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_write = 1'b0;
        req_size  = 3'd0;
        hrdata    = '0;
        hready    = 1'b1;
        hresp     = 2'b00;
        repeat (3) tick;
        check_reset_outputs("rst");
        hreset = 1'b0;
        tick;
        check_eq("rst_release_ready", req_ready, 1);

        // Word write 0x100
        do_xfer("wr100", 32'h100, 32'hDEADBEEF, 1'b1, 3'd2, 1'b0, 32'h0);

        // Alignment table
        do_xfer("hw101", 32'h101, 32'h0, 1'b0, 3'd1, 1'b1, 32'h0);
        do_xfer("w102",  32'h102, 32'h0, 1'b1, 3'd2, 1'b1, 32'h0);
        do_xfer("sz3",   32'h100, 32'h0, 1'b0, 3'd3, 1'b1, 32'h0);
        do_xfer("hw102", 32'h102, 32'h0, 1'b0, 3'd1, 1'b0, 32'hA5A5C3C3);
        do_xfer("b103",  32'h103, 32'h77, 1'b1, 3'd0, 1'b0, 32'h0);

        // Word read 0x104 with three DATA wait states
        check_eq("rd104_ready_pre", req_ready, 1);
        req_valid = 1'b1; req_addr = 32'h104; req_write = 1'b0; req_size = 3'd2;
        tick;                                    // N+1 ADDR
        req_valid = 1'b0;
        check_eq("rd104_addr_htrans", htrans, 2'b10);
        check_eq("rd104_addr_hwrite", hwrite, 0);
        tick;                                    // N+2 DATA
        hready = 1'b0; hrdata = 32'hBAD0BAD0;
        tick;                                    // N+3
        check_eq("rd104_wait_htrans", htrans, 2'b00);
        check_eq("rd104_wait_rvalid", rsp_valid, 0);
        tick;                                    // N+4
        check_eq("rd104_wait2_rvalid", rsp_valid, 0);
        tick;                                    // N+5
        check_eq("rd104_wait3_rvalid", rsp_valid, 0);
        hready = 1'b1; hrdata = 32'h12345678;
        tick;                                    // N+6 RESP
        check_eq("rd104_resp_rvalid", rsp_valid, 1);
        check_eq("rd104_resp_rdata",  rsp_rdata, 32'h12345678);
        check_eq("rd104_resp_rerr",   rsp_err,   0);
        hrdata = 32'h0;
        tick;
        check_eq("rd104_post_rvalid", rsp_valid, 0);

        // Read 0x108 with two-cycle ERROR response
        req_valid = 1'b1; req_addr = 32'h108; req_write = 1'b0; req_size = 3'd2;
        tick;                                    // ADDR
        req_valid = 1'b0;
        tick;                                    // DATA
        hresp = 2'b01; hready = 1'b0;
        tick;
        check_eq("err_first_rvalid", rsp_valid, 0);
        hready = 1'b1; hrdata = 32'hFFFFFFFF;
        tick;                                    // RESP
        check_eq("err_resp_rvalid", rsp_valid, 1);
        check_eq("err_resp_rerr",   rsp_err,   1);
        check_eq("err_resp_rdata",  rsp_rdata, 0);
        hresp = 2'b00; hrdata = 32'h0;
        tick;
        check_eq("err_post_rvalid", rsp_valid, 0);
        check_eq("err_hold_rerr",   rsp_err,   1);
        check_eq("err_post_ready",  req_ready, 1);

        // Reset during DATA
        req_valid = 1'b1; req_addr = 32'h10C; req_write = 1'b1; req_wdata = 32'hCAFEF00D; req_size = 3'd2;
        tick;                                    // ADDR
        req_valid = 1'b0;
        tick;                                    // DATA
        hready = 1'b0;
        hreset = 1'b1;
        tick;
        check_reset_outputs("abort");
        hreset = 1'b0; hready = 1'b1;
        tick;
        check_eq("abort_release_ready", req_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid) seen = 1'b1;
            tick;
        end
        check_eq("abort_no_rsp", seen, 0);

        // Stall with hready held low
        check_eq("to_ready_pre", req_ready, 1);
        req_valid = 1'b1; req_addr = 32'h110; req_write = 1'b0; req_size = 3'd2;
        hready = 1'b0;
        tick;                                    // N+1 ADDR, stalled
        req_valid = 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            check_eq("to_stall_rvalid", rsp_valid, 0);
            check_eq("to_stall_htrans", htrans, 2'b10);
            tick;
        end
        check_eq("to_resp_rvalid", rsp_valid, 1);
        check_eq("to_resp_rerr",   rsp_err,   1);
        check_eq("to_resp_htrans", htrans,    2'b00);
        tick;
        check_eq("to_post_rvalid", rsp_valid, 0);
`else
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid || htrans != 2'b10) seen = 1'b1;
            tick;
        end
        check_eq("nto_still_waiting", seen, 0);
`endif
        hreset = 1'b1;
        tick;
        check_eq("end_rst_htrans", htrans, 2'b00);
        hreset = 1'b0; hready = 1'b1;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_master.md
AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the address and data width.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 256, giving the wait-state limit used when the timeout feature is enabled.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- hclk_i  in  1  sole clock; all state changes on its rising edge.
- hreset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
- req_addr_i  in  DATA_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_write_i  in  1  1 = write, 0 = read.
- req_size_i  in  3  AHB size encoding.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  DATA_WIDTH  read data.
- rsp_err_o  out  1  transfer failed.
- haddr_o  out  DATA_WIDTH  AHB address.
- htrans_o  out  2  AHB transfer type.
- hwrite_o  out  1  AHB write.
- hsize_o  out  3  AHB size.
- hwdata_o  out  DATA_WIDTH  AHB write data.
- hrdata_i  in  DATA_WIDTH  AHB read data.
- hready_i  in  1  AHB ready.
- hresp_i  in  2  AHB response; 2'b00 = OKAY, 2'b01 = ERROR.

Function
REQ-004 The FSM SHALL have the states IDLE, ADDR, DATA and RESP, with one outstanding transfer at a time.
REQ-005 IDLE behaviour:
- req_ready_o SHALL be 1 only in IDLE.
- On a handshake (req_valid_i && req_ready_o), the block SHALL register addr, wdata, write and size.
REQ-006 Accepted requests SHALL go to ADDR, except as follows.
- Size > 2, a halfword with addr[0]=1, or a word with addr[1:0]≠0 SHALL go directly to RESP with rsp_err_o=1.
- No bus activity SHALL occur for these requests.
REQ-007 In ADDR, the block SHALL drive htrans_o=2'b10 (NONSEQ) plus the registered haddr_o, hwrite_o and hsize_o.
- It SHALL hold these outputs until hready_i=1, then move to DATA.
REQ-008 In DATA, htrans_o SHALL be 2'b00 (IDLE).
- hwdata_o SHALL carry the registered wdata.
- The block SHALL stay in DATA while hready_i=0.
REQ-009 DATA exit on hready_i=1 with hresp_i=OKAY:
- For reads, the block SHALL capture hrdata_i into rsp_rdata_o.
- The block SHALL then enter RESP with rsp_err_o=0.
REQ-010 DATA exit on hresp_i=ERROR:
- The block SHALL wait for hready_i=1 (second ERROR cycle).
- It SHALL then enter RESP with rsp_err_o=1 and rsp_rdata_o=0.
REQ-011 In RESP, rsp_valid_o SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
- rsp_rdata_o and rsp_err_o SHALL hold until the next response.
REQ-012 Latency with zero wait states SHALL be as follows:
- Handshake at edge N; ADDR in cycle N+1; DATA in cycle N+2; rsp_valid_o in cycle N+3.
- Each hready_i=0 cycle SHALL add one cycle.
- A rejected misaligned request SHALL give rsp_valid_o in cycle N+1.
REQ-013 htrans_o SHALL be 2'b10 only in ADDR and SHALL never be 2'b01 or 2'b11.
REQ-014 A new request SHALL NOT be accepted in the same cycle rsp_valid_o=1.
- The earliest next handshake SHALL be one cycle after RESP.

Reset
REQ-015 While hreset_i=1 on a rising edge, the block SHALL reset to IDLE with these outputs:
- req_ready_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
- htrans_o=2'b00, haddr_o=0, hwrite_o=0, hsize_o=0, hwdata_o=0.
REQ-016 On the first cycle after reset is released, req_ready_o SHALL be 1.
REQ-017 Reset asserted during ADDR or DATA SHALL abort the transfer.
- htrans_o SHALL return to IDLE on the next edge.
- No response SHALL be produced for the aborted request.

Configuration
REQ-018 When AHB_MASTER_TIMEOUT_EN is defined:
- A counter SHALL count consecutive cycles in ADDR/DATA with hready_i=0, and SHALL clear on hready_i=1.
- When the count reaches TIMEOUT_CYCLES, the block SHALL go to RESP with rsp_err_o=1 and drive htrans_o=2'b00 from the next cycle.
REQ-019 When AHB_MASTER_TIMEOUT_EN is undefined:
- No counter SHALL exist.
- TIMEOUT_CYCLES SHALL be ignored.
- The block SHALL wait indefinitely.

Verification
REQ-020 Word write, addr 0x100, wdata 0xDEADBEEF, hready_i always 1 -> the bench SHALL check all of the following:
- htrans_o=2'b10 with haddr_o=0x100 and hwrite_o=1 in cycle N+1.
- hwdata_o=0xDEADBEEF in cycle N+2.
- rsp_valid_o=1 with rsp_err_o=0 in cycle N+3.
REQ-021 Word read, addr 0x104, slave inserts 3 hready_i=0 cycles in DATA, returns 0x12345678 -> rsp_valid_o at N+6 with rsp_rdata_o=0x12345678.
REQ-022 Read with hresp_i=ERROR for 2 cycles (hready_i 0 then 1) -> rsp_valid_o one cycle later with rsp_err_o=1 and rsp_rdata_o=0.
REQ-023 Halfword at addr 0x101 -> no NONSEQ issued; rsp_valid_o=1 with rsp_err_o=1 at N+1.
REQ-024 hreset_i asserted during DATA -> all outputs as in REQ-015; req_ready_o=1 after release; no rsp_valid_o.
REQ-025 With AHB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, hready_i held 0 -> rsp_err_o=1 after 4 stalled cycles; without the macro -> no response.
